// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_pkg                                                     |
// | Description : Shared constants and helpers for the FIFO-fed UART TX lane.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_par   = 3'd3;
    localparam logic [2:0] c_st_stop  = 3'd4;

    // Clocks per serial bit; truncating division.
    function automatic int calc_div(input longint clk_freq, input longint baud_rate);
        return int'(clk_freq / baud_rate);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo_if                                              |
// | Description : Write-side handshake and line outputs of one UART TX lane.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 start_tx;
    logic [DATA_BITS-1:0] data_tx;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_overflow;
    logic                 tx_out;

    modport master (
        output start_tx, data_tx,
        input  tx_ready, tx_busy, tx_done, tx_overflow, tx_out
    );

    modport slave (
        input  start_tx, data_tx,
        output tx_ready, tx_busy, tx_done, tx_overflow, tx_out
    );
endinterface
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_sync_fifo                                               |
// | Description : Single-clock FIFO with wrap-bit full/empty detection.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_wdata,
    input  wire logic             i_pop,
    output logic      [WIDTH-1:0] o_rdata,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int c_aw = $clog2(DEPTH);

    logic [c_aw:0]      r_wptr;
    logic [c_aw:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    // Full when the index bits match but the lap bit differs.
    assign o_full    = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                       (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
    assign o_empty   = (r_wptr == r_rptr);
    assign o_rdata   = r_mem[r_rptr[c_aw-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[c_aw-1:0]] <= i_wdata;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_tx_fifo                                                 |
// | Description : Parametrised UART transmitter fed by a small write FIFO.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input wire logic     clk,
    input wire logic     rst,
    uart_tx_fifo_if.slave tx_if
);
    localparam int c_div    = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int c_baud_w = (c_div > 2) ? $clog2(c_div) : 1;

    if (c_div < 2) begin : g_bad_div
        $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
    end
    if ($bits(tx_if.data_tx) != DATA_BITS) begin : g_bad_if_width
        $error("uart_tx_fifo: interface DATA_BITS does not match module DATA_BITS");
    end

    logic [2:0]           r_state;
    logic [c_baud_w-1:0]  r_baud;
    logic [3:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx_out;
    logic                 r_done_pend;
    logic                 r_done;

    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_rdata;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_baud_last;
    logic                 w_data_last;
    logic                 w_stop_last;
    logic                 w_frame_end;
    logic                 w_line;

    assign w_push      = tx_if.start_tx && !w_full;
    assign w_baud_last = (r_baud == c_baud_w'(c_div - 1));
    assign w_data_last = (r_bit == 4'(DATA_BITS - 1));
    assign w_stop_last = (r_bit == 4'(STOP_BITS - 1));
    assign w_frame_end = (r_state == c_st_stop) && w_baud_last && w_stop_last;
    // The last stop-bit cycle reloads directly so frames run back to back.
    assign w_pop       = ((r_state == c_st_idle) || w_frame_end) && !w_empty;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (tx_if.data_tx),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_line = 1'b1;
        case (r_state)
            c_st_start: w_line = 1'b0;
            c_st_data:  w_line = r_shift[0];
            c_st_par:   w_line = r_par;
            default:    w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_par       <= 1'b0;
            r_tx_out    <= 1'b1;
            r_done_pend <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // The line is registered one cycle behind the state, so done is too.
            r_tx_out    <= w_line;
            r_done_pend <= w_frame_end;
            r_done      <= r_done_pend;

            if (r_state == c_st_idle) begin
                r_baud <= '0;
            end else begin
                r_baud <= w_baud_last ? '0 : r_baud + 1'b1;
            end

            if (w_pop) begin
                r_shift <= w_rdata;
                r_par   <= (^w_rdata) ^ (PARITY == PAR_ODD);
            end

            case (r_state)
                c_st_idle: begin
                    if (!w_empty) r_state <= c_st_start;
                end
                c_st_start: begin
                    if (w_baud_last) begin
                        r_state <= c_st_data;
                        r_bit   <= '0;
                    end
                end
                c_st_data: begin
                    if (w_baud_last) begin
                        r_shift <= r_shift >> 1;
                        if (w_data_last) begin
                            r_state <= (PARITY != PAR_NONE) ? c_st_par : c_st_stop;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                c_st_par: begin
                    if (w_baud_last) begin
                        r_state <= c_st_stop;
                        r_bit   <= '0;
                    end
                end
                c_st_stop: begin
                    if (w_baud_last) begin
                        if (w_stop_last) begin
                            r_state <= w_empty ? c_st_idle : c_st_start;
                            r_bit   <= '0;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign tx_if.tx_ready    = !w_full;
    assign tx_if.tx_busy     = (r_state != c_st_idle);
    assign tx_if.tx_done     = r_done;
    assign tx_if.tx_overflow = tx_if.start_tx && w_full;
    assign tx_if.tx_out      = r_tx_out;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_tx_fifo                                              |
// | Description : Self-checking bench for three uart_tx_fifo configurations.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int c_clk_freq = 50000000;
    localparam int c_baud     = 5000000;
    localparam int c_div      = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   exp_q[$];

    // Per-lane configuration: a = 8N1, b = 7E2, c = 8O1.
    int cfg_bits [3] = '{8, 7, 8};
    int cfg_par  [3] = '{PAR_NONE, PAR_EVEN, PAR_ODD};
    int cfg_stop [3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if_b ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if_c ();

    uart_tx_fifo #(.CLK_FREQ(c_clk_freq), .BAUD_RATE(c_baud), .DATA_BITS(8),
                   .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_a (.clk(clk), .rst(rst), .tx_if(if_a));
    uart_tx_fifo #(.CLK_FREQ(c_clk_freq), .BAUD_RATE(c_baud), .DATA_BITS(7),
                   .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(4))
        dut_b (.clk(clk), .rst(rst), .tx_if(if_b));
    uart_tx_fifo #(.CLK_FREQ(c_clk_freq), .BAUD_RATE(c_baud), .DATA_BITS(8),
                   .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4))
        dut_c (.clk(clk), .rst(rst), .tx_if(if_c));

    logic [2:0] w_line, w_done, w_busy, w_ready, w_ovf;
    assign w_line  = {if_c.tx_out,      if_b.tx_out,      if_a.tx_out};
    assign w_done  = {if_c.tx_done,     if_b.tx_done,     if_a.tx_done};
    assign w_busy  = {if_c.tx_busy,     if_b.tx_busy,     if_a.tx_busy};
    assign w_ready = {if_c.tx_ready,    if_b.tx_ready,    if_a.tx_ready};
    assign w_ovf   = {if_c.tx_overflow, if_b.tx_overflow, if_a.tx_overflow};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic st, input int d);
        case (sel)
            0:       begin if_a.start_tx = st; if_a.data_tx = 8'(d); end
            1:       begin if_b.start_tx = st; if_b.data_tx = 7'(d); end
            default: begin if_c.start_tx = st; if_c.data_tx = 8'(d); end
        endcase
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits.
    function automatic void push_frame(input int data, input int dbits, input int par, input int stops);
        int ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 0; i < dbits; i++) begin
            exp_q.push_back(bit'((data >> i) & 1));
            ones += (data >> i) & 1;
        end
        if (par == PAR_EVEN) exp_q.push_back(bit'(ones % 2));
        else if (par == PAR_ODD) exp_q.push_back(bit'(1 - (ones % 2)));
        for (int i = 0; i < stops; i++) exp_q.push_back(1'b1);
    endfunction

    // Entered k0 edges after the write edge N; line starts at N+2, frames contiguous.
    task automatic check_stream(input int sel, input string name, input int k0, input int nframes);
        int   len = exp_q.size() * c_div;
        int   fl  = len / nframes;
        int   idx;
        int   bad_bit  = 0;
        int   idle_bad = 0;
        int   done_bad = 0;
        int   busy_bad = 0;
        logic exp_line, exp_done, exp_busy;
        for (int k = k0 + 1; k <= len + 6; k++) begin
            step();
            idx      = k - 2;
            exp_line = (idx >= 0 && idx < len) ? exp_q[idx / c_div] : 1'b1;
            exp_done = (idx > 0) && (idx % fl == 0) && (idx / fl <= nframes);
            exp_busy = (k <= len);
            if (w_line[sel] !== exp_line) begin
                if (idx >= 0 && idx < len) bad_bit++;
                else idle_bad++;
            end
            if (w_done[sel] !== exp_done) done_bad++;
            if (w_busy[sel] !== exp_busy) busy_bad++;
            if (idx >= 0 && idx < len && (idx % c_div) == c_div - 1) begin
                n_checks++;
                if (bad_bit != 0) begin
                    n_errors++;
                    $display("FAIL %s bit%0d: tx_out wrong in %0d of %0d cycles, required level %0b",
                             name, idx / c_div, bad_bit, c_div, exp_line);
                end
                bad_bit = 0;
            end
        end
        n_checks++;
        if (idle_bad != 0) begin
            n_errors++;
            $display("FAIL %s idle_line: %0d cycles not high, required 0", name, idle_bad);
        end
        n_checks++;
        if (done_bad != 0) begin
            n_errors++;
            $display("FAIL %s tx_done: %0d cycles wrong, required 0 (pulses at N+2+k*%0d)", name, done_bad, fl);
        end
        n_checks++;
        if (busy_bad != 0) begin
            n_errors++;
            $display("FAIL %s tx_busy: %0d cycles wrong, required 0", name, busy_bad);
        end
    endtask

    task automatic send_one(input int sel, input string name, input int data);
        exp_q.delete();
        push_frame(data, cfg_bits[sel], cfg_par[sel], cfg_stop[sel]);
        drive(sel, 1'b1, data);
        step();
        drive(sel, 1'b0, 0);
        check_stream(sel, name, 0, 1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 0);
        step();
        step();
        n_checks++;
        if (w_line !== 3'b111) begin n_errors++; $display("FAIL reset_tx_out: got %b required 111", w_line); end
        n_checks++;
        if (w_ready !== 3'b111) begin n_errors++; $display("FAIL reset_tx_ready: got %b required 111", w_ready); end
        n_checks++;
        if (w_busy !== 3'b000) begin n_errors++; $display("FAIL reset_tx_busy: got %b required 000", w_busy); end
        n_checks++;
        if (w_done !== 3'b000) begin n_errors++; $display("FAIL reset_tx_done: got %b required 000", w_done); end
        n_checks++;
        if (w_ovf !== 3'b000) begin n_errors++; $display("FAIL reset_tx_overflow: got %b required 000", w_ovf); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_8n1();
        send_one(0, "8n1_55", 8'h55);
    endtask

    task automatic test_7e2();
        send_one(1, "7e2_41", 7'h41);
    endtask

    task automatic test_odd_parity();
        send_one(2, "odd_00", 8'h00);
        send_one(2, "odd_01", 8'h01);
    endtask

    task automatic test_back_to_back();
        logic exp_ready, exp_ovf;
        exp_q.delete();
        for (int w = 0; w < 5; w++) push_frame(8'h11 * (w + 1), 8, PAR_NONE, 1);
        for (int i = 0; i < 6; i++) begin
            drive(0, 1'b1, 8'h11 * (i + 1));
            #1;
            exp_ready = (i < 5);
            exp_ovf   = (i == 5);
            n_checks++;
            if (w_ready[0] !== exp_ready) begin
                n_errors++;
                $display("FAIL b2b_ready[%0d]: got %b required %b", i, w_ready[0], exp_ready);
            end
            n_checks++;
            if (w_ovf[0] !== exp_ovf) begin
                n_errors++;
                $display("FAIL b2b_overflow[%0d]: got %b required %b", i, w_ovf[0], exp_ovf);
            end
            step();
        end
        drive(0, 1'b0, 0);
        #1;
        n_checks++;
        if (w_ovf[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_overflow_end: got %b required 0", w_ovf[0]); end
        check_stream(0, "b2b", 5, 5);
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        drive(0, 1'b1, 8'hFF); step();
        drive(0, 1'b1, 8'h12); step();
        drive(0, 1'b1, 8'h34); step();
        drive(0, 1'b0, 0);
        n_checks++;
        if (w_line[0] !== 1'b0) begin n_errors++; $display("FAIL rstmid_start: got %b required 0", w_line[0]); end
        repeat (42) step();
        n_checks++;
        if (w_busy[0] !== 1'b1) begin n_errors++; $display("FAIL rstmid_busy_before: got %b required 1", w_busy[0]); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (w_line[0] !== 1'b1) begin n_errors++; $display("FAIL rstmid_tx_out: got %b required 1", w_line[0]); end
        n_checks++;
        if (w_busy[0] !== 1'b0) begin n_errors++; $display("FAIL rstmid_tx_busy: got %b required 0", w_busy[0]); end
        n_checks++;
        if (w_ready[0] !== 1'b1) begin n_errors++; $display("FAIL rstmid_tx_ready: got %b required 1", w_ready[0]); end
        n_checks++;
        if (w_done[0] !== 1'b0) begin n_errors++; $display("FAIL rstmid_tx_done: got %b required 0", w_done[0]); end
        for (int k = 0; k < 150; k++) begin
            step();
            if (w_line[0] !== 1'b1 || w_done[0] !== 1'b0 || w_busy[0] !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL rstmid_flushed: %0d active cycles, required 0", bad); end
        send_one(0, "rstmid_A5", 8'hA5);
    endtask

    task automatic test_random();
        int data, n, accepted;
        for (int r = 0; r < 6; r++) begin
            data = int'($urandom) & ((1 << cfg_bits[r % 3]) - 1);
            send_one(r % 3, "rand_single", data);
        end
        // Burst: the first word leaves the FIFO immediately, so DEPTH+1 fit.
        n = int'($urandom_range(2, 7));
        accepted = (n < 5) ? n : 5;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            data = int'($urandom) & 8'hFF;
            if (i < accepted) push_frame(data, 8, PAR_NONE, 1);
            drive(0, 1'b1, data);
            step();
        end
        drive(0, 1'b0, 0);
        check_stream(0, "rand_burst", n - 1, accepted);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 0);
        test_reset();
        test_8n1();
        test_7e2();
        test_odd_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
